// File: rtl/forward_if.sv
// ---------------------------------------------------------------------------
// forward_if
//   Bundles the register-index fields and write controls that the pipeline
//   presents to the forwarding unit, plus the select lines the unit returns.
//
//   master : pipeline side. Drives the register fields and controls and
//            receives the selects.
//   slave  : forwarding unit side. Receives the fields and drives the selects.
//
//   Fields : IdEx_Rs/Rt, IfId_Rs/Rt, ExMem_Rs/Rt, ExMem_Rd, MemWb_Rd
//   Ctrl   : ExMem_Reg_Wr_Control, MemWb_Reg_Wr_Control, MemWb_MemRead,
//            Ctrl_Branch
//   Selects: FwdRs, FwdRt, Fwd_IfId_Rs, Fwd_IfId_Rt (2 bit each), FwdPc
// ---------------------------------------------------------------------------
interface forward_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] IdEx_Rs;
    logic [REG_ADDR_W-1:0] IdEx_Rt;
    logic [REG_ADDR_W-1:0] ExMem_Rd;
    logic [REG_ADDR_W-1:0] MemWb_Rd;
    logic [REG_ADDR_W-1:0] ExMem_Rs;
    logic [REG_ADDR_W-1:0] ExMem_Rt;
    logic                  ExMem_Reg_Wr_Control;
    logic                  MemWb_Reg_Wr_Control;
    logic [REG_ADDR_W-1:0] IfId_Rs;
    logic [REG_ADDR_W-1:0] IfId_Rt;
    logic                  Ctrl_Branch;
    logic                  MemWb_MemRead;

    logic [1:0]            FwdRs;
    logic [1:0]            FwdRt;
    logic                  FwdPc;
    logic [1:0]            Fwd_IfId_Rs;
    logic [1:0]            Fwd_IfId_Rt;

    modport master (
        output IdEx_Rs, IdEx_Rt, ExMem_Rd, MemWb_Rd, ExMem_Rs, ExMem_Rt,
               ExMem_Reg_Wr_Control, MemWb_Reg_Wr_Control, IfId_Rs, IfId_Rt,
               Ctrl_Branch, MemWb_MemRead,
        input  FwdRs, FwdRt, FwdPc, Fwd_IfId_Rs, Fwd_IfId_Rt
    );

    modport slave (
        input  IdEx_Rs, IdEx_Rt, ExMem_Rd, MemWb_Rd, ExMem_Rs, ExMem_Rt,
               ExMem_Reg_Wr_Control, MemWb_Reg_Wr_Control, IfId_Rs, IfId_Rt,
               Ctrl_Branch, MemWb_MemRead,
        output FwdRs, FwdRt, FwdPc, Fwd_IfId_Rs, Fwd_IfId_Rt
    );
endinterface

// File: rtl/forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
//   Data-forwarding controller for the 5-stage pipeline. Compares source
//   fields in ID/EX, IF/ID and EX/MEM against the EX/MEM and MEM/WB
//   destinations and produces registered operand selects.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset; clears every select
//     fwd  - forward_if.slave (register fields in, selects out)
//
//   Select encoding: 00 = register file / pipeline value,
//                    10 = EX/MEM result, 01 = MEM/WB result.
//   Selects are decoded from the fields sampled at a rising edge and are
//   held until the next edge, so they line up with the pipeline registers.
// ---------------------------------------------------------------------------
module forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 0
) (
    input  logic     clk,
    input  logic     rst,
    forward_if.slave fwd
);

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = ZERO_REG[REG_ADDR_W-1:0];

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    // A destination forwards only when its instruction writes back and it
    // is not the hard-wired zero register.
    function automatic logic destHit(
        input logic                  wrEn,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] src
    );
        return wrEn && (rd != ZERO_IDX) && (rd == src);
    endfunction

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    function automatic logic [1:0] selectFor(
        input logic exHit,
        input logic wbHit
    );
        if (exHit)
            return SEL_EX;
        else if (wbHit)
            return SEL_WB;
        else
            return SEL_REG;
    endfunction

    logic [1:0] fwdRs_p0;
    logic [1:0] fwdRt_p0;
    logic       fwdPc_p0;
    logic [1:0] fwdIfIdRs_p0;
    logic [1:0] fwdIfIdRt_p0;

    logic [1:0] fwdRs_p1;
    logic [1:0] fwdRt_p1;
    logic       fwdPc_p1;
    logic [1:0] fwdIfIdRs_p1;
    logic [1:0] fwdIfIdRt_p1;

    // Stage p0: combinational decode of the current field values
    always_comb begin
        fwdRs_p0     = SEL_REG;
        fwdRt_p0     = SEL_REG;
        fwdPc_p0     = 1'b0;
        fwdIfIdRs_p0 = SEL_REG;
        fwdIfIdRt_p0 = SEL_REG;

        fwdRs_p0 = selectFor(
            destHit(fwd.ExMem_Reg_Wr_Control, fwd.ExMem_Rd, fwd.IdEx_Rs),
            destHit(fwd.MemWb_Reg_Wr_Control, fwd.MemWb_Rd, fwd.IdEx_Rs));
        fwdRt_p0 = selectFor(
            destHit(fwd.ExMem_Reg_Wr_Control, fwd.ExMem_Rd, fwd.IdEx_Rt),
            destHit(fwd.MemWb_Reg_Wr_Control, fwd.MemWb_Rd, fwd.IdEx_Rt));

        // Branch operands are only redirected when ID holds a branch.
        if (fwd.Ctrl_Branch) begin
            fwdIfIdRs_p0 = selectFor(
                destHit(fwd.ExMem_Reg_Wr_Control, fwd.ExMem_Rd, fwd.IfId_Rs),
                destHit(fwd.MemWb_Reg_Wr_Control, fwd.MemWb_Rd, fwd.IfId_Rs));
            fwdIfIdRt_p0 = selectFor(
                destHit(fwd.ExMem_Reg_Wr_Control, fwd.ExMem_Rd, fwd.IfId_Rt),
                destHit(fwd.MemWb_Reg_Wr_Control, fwd.MemWb_Rd, fwd.IfId_Rt));
        end

        // Load data in MEM/WB feeding an operand still in MEM (e.g. a store).
        fwdPc_p0 = fwd.MemWb_MemRead &&
                   (destHit(fwd.MemWb_Reg_Wr_Control, fwd.MemWb_Rd, fwd.ExMem_Rs) ||
                    destHit(fwd.MemWb_Reg_Wr_Control, fwd.MemWb_Rd, fwd.ExMem_Rt));
    end

    // Stage p1: selects registered alongside the pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fwdRs_p1     <= SEL_REG;
            fwdRt_p1     <= SEL_REG;
            fwdPc_p1     <= 1'b0;
            fwdIfIdRs_p1 <= SEL_REG;
            fwdIfIdRt_p1 <= SEL_REG;
        end else begin
            fwdRs_p1     <= fwdRs_p0;
            fwdRt_p1     <= fwdRt_p0;
            fwdPc_p1     <= fwdPc_p0;
            fwdIfIdRs_p1 <= fwdIfIdRs_p0;
            fwdIfIdRt_p1 <= fwdIfIdRt_p0;
        end
    end

    assign fwd.FwdRs       = fwdRs_p1;
    assign fwd.FwdRt       = fwdRt_p1;
    assign fwd.FwdPc       = fwdPc_p1;
    assign fwd.Fwd_IfId_Rs = fwdIfIdRs_p1;
    assign fwd.Fwd_IfId_Rt = fwdIfIdRt_p1;

endmodule

// File: tb/tb_forward_unit.sv
module tb_forward_unit;

    logic clk = 1'b0;
    logic rst;
    int   nCompared   = 0;
    int   nMismatched = 0;

    forward_if #(.REG_ADDR_W(5)) bus ();

    forward_unit #(.REG_ADDR_W(5), .ZERO_REG(0)) dut (
        .clk (clk),
        .rst (rst),
        .fwd (bus.slave)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.IdEx_Rs = '0;  bus.IdEx_Rt = '0;
        bus.ExMem_Rd = '0; bus.MemWb_Rd = '0;
        bus.ExMem_Rs = '0; bus.ExMem_Rt = '0;
        bus.ExMem_Reg_Wr_Control = 1'b0;
        bus.MemWb_Reg_Wr_Control = 1'b0;
        bus.IfId_Rs = '0;  bus.IfId_Rt = '0;
        bus.Ctrl_Branch = 1'b0;
        bus.MemWb_MemRead = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        bus.IdEx_Rs = 5'b11011; bus.IdEx_Rt = 5'b11011;
        bus.ExMem_Rd = 5'b11011; bus.ExMem_Reg_Wr_Control = 1'b1;
        bus.IfId_Rs = 5'b11011; bus.Ctrl_Branch = 1'b1;
        bus.MemWb_Rd = 5'b00111; bus.ExMem_Rt = 5'b00111;
        bus.MemWb_MemRead = 1'b1; bus.MemWb_Reg_Wr_Control = 1'b1;
        rst = 1'b1;
        tick();
        nCompared++;
        if ({bus.FwdRs, bus.FwdRt, bus.FwdPc, bus.Fwd_IfId_Rs, bus.Fwd_IfId_Rt} !== 9'b0) begin
            nMismatched++;
            $display("FAIL reset_all got %b want %b",
                     {bus.FwdRs, bus.FwdRt, bus.FwdPc, bus.Fwd_IfId_Rs, bus.Fwd_IfId_Rt}, 9'b0);
        end
        // Release reset with the same matching inputs: everything lights up.
        rst = 1'b0;
        tick();
        nCompared++;
        if ({bus.FwdRs, bus.FwdRt, bus.FwdPc, bus.Fwd_IfId_Rs} !== 7'b10_10_1_10) begin
            nMismatched++;
            $display("FAIL after_reset got %b want %b",
                     {bus.FwdRs, bus.FwdRt, bus.FwdPc, bus.Fwd_IfId_Rs}, 7'b10_10_1_10);
        end
        // Reset in the middle of operation overrides the pending match.
        rst = 1'b1;
        tick();
        nCompared++;
        if ({bus.FwdRs, bus.FwdRt, bus.FwdPc, bus.Fwd_IfId_Rs, bus.Fwd_IfId_Rt} !== 9'b0) begin
            nMismatched++;
            $display("FAIL midop_reset got %b want %b",
                     {bus.FwdRs, bus.FwdRt, bus.FwdPc, bus.Fwd_IfId_Rs, bus.Fwd_IfId_Rt}, 9'b0);
        end
        rst = 1'b0;
        clearInputs();
        tick();
    endtask

    task automatic test_ex_fwd();
        clearInputs();
        bus.IdEx_Rs = 5'b11011; bus.ExMem_Rd = 5'b11011;
        bus.ExMem_Reg_Wr_Control = 1'b1;
        // Before the edge the registered output must still be the old value.
        #1;
        nCompared++;
        if (bus.FwdRs !== 2'b00) begin
            nMismatched++;
            $display("FAIL latency_hold got %b want %b", bus.FwdRs, 2'b00);
        end
        tick();
        nCompared++;
        if (bus.FwdRs !== 2'b10) begin
            nMismatched++;
            $display("FAIL ex_rs got %b want %b", bus.FwdRs, 2'b10);
        end
        nCompared++;
        if (bus.FwdRt !== 2'b00) begin
            nMismatched++;
            $display("FAIL ex_rt_idle got %b want %b", bus.FwdRt, 2'b00);
        end

        bus.ExMem_Rd = 5'b00000; bus.MemWb_Rd = 5'b11011;
        bus.MemWb_Reg_Wr_Control = 1'b1;
        tick();
        nCompared++;
        if (bus.FwdRs !== 2'b01) begin
            nMismatched++;
            $display("FAIL wb_rs got %b want %b", bus.FwdRs, 2'b01);
        end

        bus.IdEx_Rs = 5'b01010; bus.ExMem_Rd = 5'b01010; bus.MemWb_Rd = 5'b01010;
        tick();
        nCompared++;
        if (bus.FwdRs !== 2'b10) begin
            nMismatched++;
            $display("FAIL priority_rs got %b want %b", bus.FwdRs, 2'b10);
        end

        // Rt alone: MEM/WB match.
        bus.IdEx_Rs = 5'b00001; bus.IdEx_Rt = 5'b01100;
        bus.ExMem_Rd = 5'b00011; bus.MemWb_Rd = 5'b01100;
        tick();
        nCompared++;
        if ({bus.FwdRs, bus.FwdRt} !== 4'b00_01) begin
            nMismatched++;
            $display("FAIL wb_rt got %b want %b", {bus.FwdRs, bus.FwdRt}, 4'b00_01);
        end

        // Both operands read the same EX/MEM destination.
        bus.IdEx_Rs = 5'b00110; bus.IdEx_Rt = 5'b00110; bus.ExMem_Rd = 5'b00110;
        tick();
        nCompared++;
        if ({bus.FwdRs, bus.FwdRt} !== 4'b10_10) begin
            nMismatched++;
            $display("FAIL both_ex got %b want %b", {bus.FwdRs, bus.FwdRt}, 4'b10_10);
        end
    endtask

    task automatic test_branch_fwd();
        clearInputs();
        bus.Ctrl_Branch = 1'b1;
        bus.IfId_Rs = 5'b10101; bus.IfId_Rt = 5'b10101;
        bus.ExMem_Rd = 5'b11011; bus.ExMem_Reg_Wr_Control = 1'b1;
        tick();
        nCompared++;
        if ({bus.Fwd_IfId_Rs, bus.Fwd_IfId_Rt} !== 4'b00_00) begin
            nMismatched++;
            $display("FAIL br_nomatch got %b want %b", {bus.Fwd_IfId_Rs, bus.Fwd_IfId_Rt}, 4'b00_00);
        end

        bus.IfId_Rs = 5'b11110; bus.MemWb_Rd = 5'b11110;
        bus.MemWb_Reg_Wr_Control = 1'b1;
        tick();
        nCompared++;
        if (bus.Fwd_IfId_Rs !== 2'b01) begin
            nMismatched++;
            $display("FAIL br_wb_rs got %b want %b", bus.Fwd_IfId_Rs, 2'b01);
        end

        bus.IfId_Rs = 5'b00101; bus.ExMem_Rd = 5'b00101;
        tick();
        nCompared++;
        if (bus.Fwd_IfId_Rs !== 2'b10) begin
            nMismatched++;
            $display("FAIL br_ex_rs got %b want %b", bus.Fwd_IfId_Rs, 2'b10);
        end

        bus.IfId_Rt = 5'b00101; bus.MemWb_Rd = 5'b00101;
        tick();
        nCompared++;
        if (bus.Fwd_IfId_Rt !== 2'b10) begin
            nMismatched++;
            $display("FAIL br_priority_rt got %b want %b", bus.Fwd_IfId_Rt, 2'b10);
        end

        bus.IfId_Rt = 5'b01001; bus.MemWb_Rd = 5'b01001;
        tick();
        nCompared++;
        if (bus.Fwd_IfId_Rt !== 2'b01) begin
            nMismatched++;
            $display("FAIL br_wb_rt got %b want %b", bus.Fwd_IfId_Rt, 2'b01);
        end
    endtask

    task automatic test_branch_gate();
        clearInputs();
        bus.IfId_Rs = 5'b11010; bus.IfId_Rt = 5'b11010;
        bus.ExMem_Rd = 5'b11010; bus.ExMem_Reg_Wr_Control = 1'b1;
        bus.Ctrl_Branch = 1'b0;
        tick();
        nCompared++;
        if ({bus.Fwd_IfId_Rs, bus.Fwd_IfId_Rt} !== 4'b00_00) begin
            nMismatched++;
            $display("FAIL br_gate_off got %b want %b", {bus.Fwd_IfId_Rs, bus.Fwd_IfId_Rt}, 4'b00_00);
        end
    endtask

    task automatic test_wr_gating();
        clearInputs();
        bus.Ctrl_Branch = 1'b1;
        bus.IfId_Rt = 5'b11110; bus.MemWb_Rd = 5'b11110;
        bus.ExMem_Rt = 5'b11110; bus.IdEx_Rt = 5'b11110;
        bus.MemWb_MemRead = 1'b1; bus.MemWb_Reg_Wr_Control = 1'b0;
        tick();
        nCompared++;
        if ({bus.Fwd_IfId_Rt, bus.FwdPc, bus.FwdRt} !== 5'b00_0_00) begin
            nMismatched++;
            $display("FAIL wb_wr_low got %b want %b", {bus.Fwd_IfId_Rt, bus.FwdPc, bus.FwdRt}, 5'b00_0_00);
        end

        clearInputs();
        bus.Ctrl_Branch = 1'b1;
        bus.IfId_Rt = 5'b11000; bus.ExMem_Rd = 5'b11000; bus.IdEx_Rs = 5'b11000;
        bus.ExMem_Reg_Wr_Control = 1'b0;
        tick();
        nCompared++;
        if ({bus.Fwd_IfId_Rt, bus.FwdRs} !== 4'b00_00) begin
            nMismatched++;
            $display("FAIL ex_wr_low got %b want %b", {bus.Fwd_IfId_Rt, bus.FwdRs}, 4'b00_00);
        end
    endtask

    task automatic test_fwdpc_zero();
        clearInputs();
        bus.MemWb_MemRead = 1'b1; bus.MemWb_Reg_Wr_Control = 1'b1;
        bus.MemWb_Rd = 5'b00111; bus.ExMem_Rt = 5'b00111;
        tick();
        nCompared++;
        if (bus.FwdPc !== 1'b1) begin
            nMismatched++;
            $display("FAIL pc_rt got %b want %b", bus.FwdPc, 1'b1);
        end

        bus.ExMem_Rt = 5'b00010; bus.ExMem_Rs = 5'b00111;
        tick();
        nCompared++;
        if (bus.FwdPc !== 1'b1) begin
            nMismatched++;
            $display("FAIL pc_rs got %b want %b", bus.FwdPc, 1'b1);
        end

        // Not a load: no MEM-stage forwarding even with a matching write.
        bus.MemWb_MemRead = 1'b0;
        tick();
        nCompared++;
        if (bus.FwdPc !== 1'b0) begin
            nMismatched++;
            $display("FAIL pc_noload got %b want %b", bus.FwdPc, 1'b0);
        end

        bus.MemWb_MemRead = 1'b1;
        bus.MemWb_Rd = 5'b00000; bus.ExMem_Rt = 5'b00000; bus.ExMem_Rs = 5'b00000;
        tick();
        nCompared++;
        if (bus.FwdPc !== 1'b0) begin
            nMismatched++;
            $display("FAIL pc_zero got %b want %b", bus.FwdPc, 1'b0);
        end

        clearInputs();
        bus.IdEx_Rs = 5'b00000; bus.IdEx_Rt = 5'b00000;
        bus.ExMem_Rd = 5'b00000; bus.ExMem_Reg_Wr_Control = 1'b1;
        bus.MemWb_Rd = 5'b00000; bus.MemWb_Reg_Wr_Control = 1'b1;
        bus.Ctrl_Branch = 1'b1;
        tick();
        nCompared++;
        if ({bus.FwdRs, bus.FwdRt, bus.Fwd_IfId_Rs, bus.Fwd_IfId_Rt} !== 8'b0) begin
            nMismatched++;
            $display("FAIL zero_reg got %b want %b",
                     {bus.FwdRs, bus.FwdRt, bus.Fwd_IfId_Rs, bus.Fwd_IfId_Rt}, 8'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();
        #2;
        test_reset();
        test_ex_fwd();
        test_branch_fwd();
        test_branch_gate();
        test_wr_gating();
        test_fwdpc_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/forward_unit.md
Name: forward_unit

Overview:
- Data-forwarding controller for the 5-stage pipelined RISC core.
- Compares source-register fields in the ID/EX, IF/ID and EX/MEM stages against destination registers in the EX/MEM and MEM/WB stages.
- Produces mux selects for the EX-stage ALU operands, the ID-stage branch comparator operands, and the MEM-stage operand path (FwdPc).
- All select outputs are registered: they are launched on the same clock edge the pipeline registers update.

Parameters:
- REG_ADDR_W, 5, register-index width.
- ZERO_REG, 0, index of hard-wired zero register; never a forwarding source.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset; synchronous, active-high.
- IdEx_Rs  input  5  ID/EX source register 1.
- IdEx_Rt  input  5  ID/EX source register 2.
- ExMem_Rd  input  5  EX/MEM destination register.
- MemWb_Rd  input  5  MEM/WB destination register.
- ExMem_Rs  input  5  EX/MEM source register 1.
- ExMem_Rt  input  5  EX/MEM source register 2 (store data).
- ExMem_Reg_Wr_Control  input  1  EX/MEM instruction writes the register file.
- MemWb_Reg_Wr_Control  input  1  MEM/WB instruction writes the register file.
- IfId_Rs  input  5  IF/ID source register 1 (branch compare).
- IfId_Rt  input  5  IF/ID source register 2 (branch compare).
- Ctrl_Branch  input  1  instruction in ID is a branch.
- MemWb_MemRead  input  1  MEM/WB instruction is a load.
- FwdRs  output  2  ALU operand A select.
- FwdRt  output  2  ALU operand B select.
- FwdPc  output  1  MEM-stage operand takes MEM/WB load data.
- Fwd_IfId_Rs  output  2  branch-compare operand A select.
- Fwd_IfId_Rt  output  2  branch-compare operand B select.

Behaviour:
- Select encoding on every 2-bit select: 00 = register file / pipeline value; 10 = EX/MEM result; 01 = MEM/WB result. 11 is never produced.
- Reset:
  - When rst is high at a rising edge, all outputs become 0.
  - Reset mid-operation overrides any pending match.
- Latency: outputs register the decode of the inputs sampled at the rising edge; they are valid one cycle later and held until the next edge.
- Match helpers:
  - exHit(r) = ExMem_Reg_Wr_Control && ExMem_Rd != ZERO_REG && ExMem_Rd == r.
  - wbHit(r) = MemWb_Reg_Wr_Control && MemWb_Rd != ZERO_REG && MemWb_Rd == r.
- FwdRs:
  - exHit(IdEx_Rs) gives 10.
  - Otherwise wbHit(IdEx_Rs) gives 01.
  - Otherwise 00.
  - EX/MEM has priority when both stages match.
- FwdRt: same as FwdRs, using IdEx_Rt.
- Fwd_IfId_Rs:
  - If Ctrl_Branch = 0, output is 00 regardless of matches.
  - Otherwise exHit(IfId_Rs) gives 10, else wbHit(IfId_Rs) gives 01, else 00.
- Fwd_IfId_Rt: same as Fwd_IfId_Rs, using IfId_Rt.
- FwdPc = MemWb_MemRead && MemWb_Reg_Wr_Control && MemWb_Rd != ZERO_REG && (MemWb_Rd == ExMem_Rs || MemWb_Rd == ExMem_Rt).
- Write-enable gating:
  - A destination match with its write-enable low never forwards.
  - MemWb_MemRead alone, without MemWb_Reg_Wr_Control, never forwards.
- Register 0 as a destination never forwards, even if a source field is 0 and write-enable is high.
- Rs and Rt decisions are independent; both may select the same stage simultaneously.

Test Plan:
- Assert rst for one edge with arbitrary matching inputs, e.g. IdEx_Rs = ExMem_Rd = 11011 with write-enable high -> all outputs 0 after that edge.
- EX-stage forwarding:
  - IdEx_Rs = ExMem_Rd = 11011, ExMem_Reg_Wr_Control = 1, MemWb write 0 -> after next edge FwdRs = 10, FwdRt = 00.
  - Then ExMem_Rd = 0, MemWb_Rd = 11011, both writes 1 -> FwdRs = 01.
  - With IdEx_Rs = ExMem_Rd = MemWb_Rd = 01010 and both writes 1 -> FwdRs = 10 (priority).
- Branch forwarding, with Ctrl_Branch = 1:
  - IfId_Rs = IfId_Rt = 10101, ExMem_Rd = 11011 -> Fwd_IfId_Rs/Rt = 00.
  - MemWb_Rd = IfId_Rs = 11110, MemWb write 1 -> Fwd_IfId_Rs = 01.
  - ExMem_Rd = IfId_Rs = 00101, ExMem write 1 -> Fwd_IfId_Rs = 10.
- Branch gate off: ExMem_Rd = IfId_Rs = 11010, ExMem write 1, Ctrl_Branch = 0 -> Fwd_IfId_Rs = 00.
- Write-enable gating:
  - MemWb_Rd = IfId_Rt = 11110, Ctrl_Branch = 1, MemWb_MemRead = 1, MemWb write 0 -> Fwd_IfId_Rt = 00, FwdPc = 0.
  - ExMem_Rd = IfId_Rt = 11000, ExMem write 0 -> Fwd_IfId_Rt = 00.
- FwdPc and zero register:
  - MemWb_MemRead = 1, MemWb write 1, MemWb_Rd = ExMem_Rt = 00111 -> FwdPc = 1.
  - Same with MemWb_Rd = ExMem_Rt = 0 -> FwdPc = 0.
  - IdEx_Rs = ExMem_Rd = 0, ExMem write 1 -> FwdRs = 00.
